mult_hilo_ctrl: RTL and testbench
=================================

Name: mult_hilo_ctrl

Overview:
- Issue and writeback stage for the iterative signed multiplier, placed between decode/execute and the multiplier.
- Accepts MULT/MULTU/MTHI/MTLO requests and drives the multiplier's begin/operand inputs, holding them stable for the whole operation.
- Captures the 64-bit product into architectural HI/LO registers and provides the busy interlock for the pipeline.

Parameters:
- OP_W, 2, width of issue_op encoding

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- issue_valid  in  1  request present
- issue_ready  out  1  request accepted this cycle when valid&ready
- issue_op  in  OP_W  00 MULT, 01 MULTU, 10 MTHI, 11 MTLO
- issue_src1  in  32  operand A / MTHI/MTLO data
- issue_src2  in  32  operand B
- mult_begin  out  1  to multiplier; held high for the entire operation
- mult_op1  out  32  latched operand A to multiplier
- mult_op2  out  32  latched operand B to multiplier
- product  in  64  signed product from multiplier, valid while mult_end=1
- mult_end  in  1  multiplier completion
- hi_rdata  out  32  current HI
- lo_rdata  out  32  current LO
- hilo_busy  out  1  multiply in flight; pipeline stalls HI/LO readers
- done_pulse  out  1  one-cycle pulse after HI/LO are updated by a multiply

Behaviour:
- Reset (async, resetn=0): state=IDLE; HI=LO=0; op_a=op_b=0; is_unsigned=0; mult_begin=0; done_pulse=0; hilo_busy=0.
- States: IDLE, BUSY, DONE.
- issue_ready = (state==IDLE).
- hilo_busy = (state!=IDLE).
- mult_begin = (state==BUSY), decoded from the state flop with no combinational path from inputs.
- IDLE, accept MULT/MULTU:
  - Latch src1→op_a and src2→op_b; record is_unsigned.
  - Next state BUSY.
- IDLE, accept MTHI/MTLO:
  - Write src1 into HI or LO at that edge; stay IDLE.
  - No done_pulse; readers see the new value next cycle.
- BUSY:
  - mult_op1/op2 stay equal to op_a/op_b throughout. The multiplier samples operand signs every cycle, so operands must not change.
  - Wait for mult_end. On the edge where mult_end=1: {HI,LO} <= result, next state DONE.
- DONE:
  - Lasts exactly one cycle. mult_begin=0 here, so the multiplier drops its internal valid and cannot restart.
  - done_pulse=1; next state IDLE.
- Latency:
  - The multiplier consumes 2 bits of |op2| per cycle. BUSY lasts 2 cycles when op2=0, and at most 18 cycles when |op2| has bit 31 or 30 set.
  - Accept-to-IDLE takes BUSY+1 cycles.
  - Back-to-back issue is possible on the first IDLE cycle.
- mult_end outside BUSY is ignored.
- Result: product as received (signed). For MULTU with the feature enabled, the unsigned correction below is applied to the high half.
- Reset asserted mid-BUSY: immediate return to IDLE with mult_begin=0. The multiplier idles on its next clock because begin is low. HI/LO cleared; no done_pulse.
- Width rule: all HI/LO arithmetic is mod 2^32. 0x80000000 operands are legal and exact for signed multiply.

Optional Feature:
- Macro: MULT_UNSIGNED_EN
- Defined:
  - MULTU produces the exact unsigned 64-bit product.
  - HI = product[63:32] + (op_a[31] ? op_b : 0) + (op_b[31] ? op_a : 0), mod 2^32; LO = product[31:0].
  - MULT is unaffected.
- Undefined:
  - is_unsigned is not stored, and MULTU executes identically to MULT (signed result).
  - No adders are instantiated.

Decomposition:
- Shared package mult_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_MTHI/OP_MTLO
  - state encoding ST_IDLE/ST_BUSY/ST_DONE
  - widths DATA_W=32, PROD_W=64
- One natural sub-module, hilo_unsigned_fix: combinational HI correction, compiled only under MULT_UNSIGNED_EN.
- FSM, operand latches and HI/LO registers stay in mult_hilo_ctrl.

Test Plan:
- MULT src1=7, src2=0xFFFFFFFD (-3) with the real multiplier attached → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also check: done_pulse exactly once; mult_begin high only in BUSY; op1/op2 stable throughout.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0; BUSY=18 cycles. Then MULT 5×0 → HI=LO=0; BUSY=2 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - with MULT_UNSIGNED_EN → HI=0xFFFFFFFE, LO=0x00000001
  - without it → HI=0, LO=1
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 issued back-to-back → both accepted in consecutive cycles; hi_rdata/lo_rdata updated; hilo_busy never set.
- MTLO held valid during a MULT → issue_ready=0 until IDLE. Then MTLO accepted and overwrites LO; HI retains the multiply result.
- resetn pulsed low mid-BUSY → outputs return to reset values asynchronously. After release, MULT 3×4 → HI=0, LO=12, with no stale product captured.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared encodings and widths for the HI/LO multiply issue/writeback controller.
package mult_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_unsigned_fix.sv
// Converts the signed high product half into the unsigned one for MULTU.
// Only exists when MULT_UNSIGNED_EN is defined.
`ifdef MULT_UNSIGNED_EN
module hilo_unsigned_fix
  import mult_pkg::*;
(
  input  logic [DATA_W-1:0] i_prod_hi,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_hi
);

  logic [DATA_W-1:0] w_add_a;
  logic [DATA_W-1:0] w_add_b;

  // A negative signed operand is short by 2^32; that adds the other operand into HI.
  always_comb begin
    w_add_a = i_op_a[DATA_W-1] ? i_op_b : '0;
    w_add_b = i_op_b[DATA_W-1] ? i_op_a : '0;
    o_hi    = i_unsigned ? (i_prod_hi + w_add_a + w_add_b) : i_prod_hi;
  end

endmodule
`endif

// File: rtl/mult_hilo_ctrl.sv
// Issue/writeback stage for the iterative multiplier: owns HI/LO and the busy interlock.
// Optional exact unsigned MULTU via MULT_UNSIGNED_EN.
module mult_hilo_ctrl
  import mult_pkg::*;
#(
  parameter int OP_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_src1,
  input  logic [DATA_W-1:0] issue_src2,
  output logic              mult_begin,
  output logic [DATA_W-1:0] mult_op1,
  output logic [DATA_W-1:0] mult_op2,
  input  logic [PROD_W-1:0] product,
  input  logic              mult_end,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata,
  output logic              hilo_busy,
  output logic              done_pulse
);

  state_e            r_state;
  state_e            w_next;
  logic              w_start;
  logic              w_wr_hi;
  logic              w_wr_lo;
  logic              w_capture;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] w_hi_result;

`ifdef MULT_UNSIGNED_EN
  logic r_unsigned;

  hilo_unsigned_fix u_fix (
    .i_prod_hi  (product[PROD_W-1:DATA_W]),
    .i_op_a     (r_op_a),
    .i_op_b     (r_op_b),
    .i_unsigned (r_unsigned),
    .o_hi       (w_hi_result)
  );
`else
  assign w_hi_result = product[PROD_W-1:DATA_W];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // mult_end is only honoured in BUSY; a stray completion elsewhere has no effect.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_wr_hi   = 1'b0;
    w_wr_lo   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (issue_valid) begin
          case (issue_op)
            OP_W'(OP_MTHI): w_wr_hi = 1'b1;
            OP_W'(OP_MTLO): w_wr_lo = 1'b1;
            default: begin
              w_start = 1'b1;
              w_next  = ST_BUSY;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (mult_end) begin
          w_capture = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op_a <= '0;
      r_op_b <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
`ifdef MULT_UNSIGNED_EN
      r_unsigned <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_op_a <= issue_src1;
        r_op_b <= issue_src2;
`ifdef MULT_UNSIGNED_EN
        r_unsigned <= (issue_op == OP_W'(OP_MULTU));
`endif
      end
      if (w_wr_hi) r_hi <= issue_src1;
      if (w_wr_lo) r_lo <= issue_src1;
      if (w_capture) begin
        r_hi <= w_hi_result;
        r_lo <= product[DATA_W-1:0];
      end
    end
  end

  // Everything facing the multiplier comes straight from flops so operands never glitch.
  assign issue_ready = (r_state == ST_IDLE);
  assign hilo_busy   = (r_state != ST_IDLE);
  assign mult_begin  = (r_state == ST_BUSY);
  assign done_pulse  = (r_state == ST_DONE);
  assign mult_op1    = r_op_a;
  assign mult_op2    = r_op_b;
  assign hi_rdata    = r_hi;
  assign lo_rdata    = r_lo;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed self-checking bench for mult_hilo_ctrl with a behavioural 2-bits-per-cycle multiplier.
// Expected MULTU results follow MULT_UNSIGNED_EN.
module tb_mult_hilo_ctrl;

  logic        clk;
  logic        resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [31:0] issue_src1;
  logic [31:0] issue_src2;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;
  logic        hilo_busy;
  logic        done_pulse;

  int compared = 0;
  int mismatched = 0;

  int   mcnt;
  logic modelEnd;
  logic strayEnd;

  mult_hilo_ctrl #(.OP_W(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_src1  (issue_src1),
    .issue_src2  (issue_src2),
    .mult_begin  (mult_begin),
    .mult_op1    (mult_op1),
    .mult_op2    (mult_op2),
    .product     (product),
    .mult_end    (mult_end),
    .hi_rdata    (hi_rdata),
    .lo_rdata    (lo_rdata),
    .hilo_busy   (hilo_busy),
    .done_pulse  (done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int latOf(input logic [31:0] b);
    logic [31:0] m;
    int bl;
    m  = b[31] ? (~b + 32'd1) : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    return 2 + (bl + 1) / 2;
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x;
    logic signed [63:0] y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  // Multiplier model: counts cycles of begin, completes after latOf(op2) cycles; garbage product otherwise.
  always @(posedge clk) begin
    if (mult_begin) mcnt <= mcnt + 1;
    else            mcnt <= 0;
  end
  assign modelEnd = mult_begin && (mcnt == latOf(mult_op2) - 1);
  assign mult_end = modelEnd | strayEnd;
  assign product  = modelEnd ? smul(mult_op1, mult_op2) : 64'hDEADBEEF_0BADF00D;

  task automatic do_mult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy, output int pulses, output bit opsOk,
                         output bit beginOk, output bit timedOut);
    busy = 0; pulses = 0; opsOk = 1; beginOk = 1; timedOut = 1;
    @(negedge clk);
    issue_valid = 1'b1; issue_op = op; issue_src1 = a; issue_src2 = b;
    @(negedge clk);
    issue_valid = 1'b0; issue_src1 = 32'h5A5A5A5A; issue_src2 = 32'hA5A5A5A5;
    for (int c = 0; c < 60; c++) begin
      if (!hilo_busy) begin
        timedOut = 0;
        break;
      end
      if (mult_begin) begin
        busy++;
        if (mult_op1 !== a || mult_op2 !== b) opsOk = 0;
        if (done_pulse) beginOk = 0;
      end else if (!done_pulse) beginOk = 0;
      if (done_pulse) pulses++;
      if (issue_ready) beginOk = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    compared++;
    if ({hi_rdata, lo_rdata, mult_op1, mult_op2} !== 128'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_regs: got %h_%h_%h_%h expected all zero", hi_rdata, lo_rdata, mult_op1, mult_op2);
    end
    compared++;
    if ({issue_ready, hilo_busy, mult_begin, done_pulse} !== 4'b1000) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 1000", {issue_ready, hilo_busy, mult_begin, done_pulse});
    end
  endtask

  task automatic test_mult_signed;
    int busy, pulses; bit opsOk, beginOk, to;
    do_mult(2'b00, 32'd7, 32'hFFFFFFFD, busy, pulses, opsOk, beginOk, to);
    compared++;
    if ({hi_rdata, lo_rdata} !== 64'hFFFFFFFF_FFFFFFEB) begin
      mismatched++;
      $display("[TB] FAIL mult_7xm3: got %h_%h expected ffffffff_ffffffeb", hi_rdata, lo_rdata);
    end
    compared++;
    if ({pulses, opsOk, beginOk, to} !== {32'd1, 1'b1, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL mult_7xm3_ctrl: got pulses=%0d ops=%0d begin=%0d timeout=%0d expected 1 1 1 0", pulses, opsOk, beginOk, to);
    end
    compared++;
    if (busy !== 3) begin
      mismatched++;
      $display("[TB] FAIL mult_7xm3_busy: got %0d expected 3", busy);
    end
  endtask

  task automatic test_mult_extremes;
    int busy, pulses; bit opsOk, beginOk, to;
    do_mult(2'b00, 32'h80000000, 32'h80000000, busy, pulses, opsOk, beginOk, to);
    compared++;
    if ({hi_rdata, lo_rdata} !== 64'h40000000_00000000) begin
      mismatched++;
      $display("[TB] FAIL mult_min_sq: got %h_%h expected 40000000_00000000", hi_rdata, lo_rdata);
    end
    compared++;
    if (busy !== 18 || to !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mult_min_sq_busy: got %0d timeout=%0d expected 18 0", busy, to);
    end
    do_mult(2'b00, 32'd5, 32'd0, busy, pulses, opsOk, beginOk, to);
    compared++;
    if ({hi_rdata, lo_rdata} !== 64'd0) begin
      mismatched++;
      $display("[TB] FAIL mult_5x0: got %h_%h expected 0", hi_rdata, lo_rdata);
    end
    compared++;
    if (busy !== 2 || pulses !== 1) begin
      mismatched++;
      $display("[TB] FAIL mult_5x0_busy: got busy=%0d pulses=%0d expected 2 1", busy, pulses);
    end
  endtask

  task automatic test_multu;
    int busy, pulses; bit opsOk, beginOk, to;
    logic [63:0] exp;
`ifdef MULT_UNSIGNED_EN
    exp = 64'hFFFFFFFE_00000001;
`else
    exp = 64'h00000000_00000001;
`endif
    do_mult(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, busy, pulses, opsOk, beginOk, to);
    compared++;
    if ({hi_rdata, lo_rdata} !== exp) begin
      mismatched++;
      $display("[TB] FAIL multu_ones: got %h_%h expected %h", hi_rdata, lo_rdata, exp);
    end
  endtask

  task automatic test_mt_back_to_back;
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 2'b10; issue_src1 = 32'h12345678;
    @(negedge clk);
    compared++;
    if ({hi_rdata, issue_ready, hilo_busy} !== {32'h12345678, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL mthi: got hi=%h ready=%b busy=%b expected 12345678 1 0", hi_rdata, issue_ready, hilo_busy);
    end
    issue_op = 2'b11; issue_src1 = 32'h9ABCDEF0;
    @(negedge clk);
    issue_valid = 1'b0;
    compared++;
    if ({hi_rdata, lo_rdata, hilo_busy, done_pulse} !== {32'h12345678, 32'h9ABCDEF0, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL mtlo_b2b: got %h_%h busy=%b done=%b expected 12345678_9abcdef0 0 0", hi_rdata, lo_rdata, hilo_busy, done_pulse);
    end
  endtask

  task automatic test_mtlo_during_mult;
    int stalls;
    int bad;
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 2'b00; issue_src1 = 32'h00010000; issue_src2 = 32'h00030000;
    @(negedge clk);
    issue_op = 2'b11; issue_src1 = 32'hCAFEF00D; issue_src2 = 32'd0;
    stalls = 0; bad = 0;
    while (hilo_busy && stalls < 60) begin
      if (issue_ready) bad++;
      stalls++;
      @(negedge clk);
    end
    compared++;
    if (bad !== 0 || stalls !== 12) begin
      mismatched++;
      $display("[TB] FAIL mtlo_stall: got ready_while_busy=%0d busy_cycles=%0d expected 0 12", bad, stalls);
    end
    compared++;
    if ({hi_rdata, lo_rdata, issue_ready} !== {32'd3, 32'd0, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL mult_before_mtlo: got %h_%h ready=%b expected 00000003_00000000 1", hi_rdata, lo_rdata, issue_ready);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    compared++;
    if ({hi_rdata, lo_rdata} !== 64'h00000003_CAFEF00D) begin
      mismatched++;
      $display("[TB] FAIL mtlo_after_mult: got %h_%h expected 00000003_cafef00d", hi_rdata, lo_rdata);
    end
  endtask

  task automatic test_stray_end;
    @(negedge clk);
    strayEnd = 1'b1;
    repeat (2) @(negedge clk);
    strayEnd = 1'b0;
    compared++;
    if ({hi_rdata, lo_rdata, hilo_busy, done_pulse} !== {64'h00000003_CAFEF00D, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL stray_end: got %h_%h busy=%b done=%b expected 00000003_cafef00d 0 0", hi_rdata, lo_rdata, hilo_busy, done_pulse);
    end
  endtask

  task automatic test_reset_mid_busy;
    int seen;
    int busy, pulses; bit opsOk, beginOk, to;
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 2'b00; issue_src1 = 32'h80000000; issue_src2 = 32'h80000000;
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (4) @(negedge clk);
    compared++;
    if (mult_begin !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_busy: got begin=%b expected 1", mult_begin);
    end
    #2 resetn = 1'b0;
    #1;
    compared++;
    if ({hi_rdata, lo_rdata, mult_op1, mult_op2, hilo_busy, mult_begin, done_pulse, issue_ready} !== {128'd0, 4'b0001}) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %h_%h_%h_%h ctrl=%b expected zeros ctrl=0001", hi_rdata, lo_rdata, mult_op1, mult_op2,
               {hilo_busy, mult_begin, done_pulse, issue_ready});
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_pulse || hilo_busy || hi_rdata != 0 || lo_rdata != 0) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_quiet: got %0d bad cycles expected 0", seen);
    end
    do_mult(2'b00, 32'd3, 32'd4, busy, pulses, opsOk, beginOk, to);
    compared++;
    if ({hi_rdata, lo_rdata, pulses} !== {32'd0, 32'd12, 32'd1}) begin
      mismatched++;
      $display("[TB] FAIL mult_3x4: got %h_%h pulses=%0d expected 00000000_0000000c 1", hi_rdata, lo_rdata, pulses);
    end
  endtask

  initial begin
    resetn = 1'b0; issue_valid = 1'b0; issue_op = 2'b00;
    issue_src1 = 32'd0; issue_src2 = 32'd0; strayEnd = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    resetn = 1'b1;
    test_mult_signed;
    test_mult_extremes;
    test_multu;
    test_mt_back_to_back;
    test_mtlo_during_mult;
    test_stray_end;
    test_reset_mid_busy;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
